// File: rtl/parity_nor_pkg.sv
// Shared types and helpers for the parity/NOR evaluator and its sweep engine.
// Holds the FSM state encoding and the legal width range.
package parity_nor_pkg;

  localparam int W_MIN = 2;
  localparam int W_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int tbl_depth(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/parity_nor_sweep_eval.sv
// Pure combinational fn: y = ~(xor of x[0..W-2] | x[W-1]).
// x[0] is the MSB of the operand.
module parity_nor_eval #(
  parameter int W = 3
) (
  input  logic [0:W-1] x,
  output logic         y
);

  assign y = ~((^x[0:W-2]) | x[W-1]);

endmodule

// File: rtl/parity_nor_sweep.sv
// Registered parity/NOR evaluator with a self-driven truth-table sweep.
// The sweep walks every operand value and accumulates the table and its popcount.
module parity_nor_sweep
  import parity_nor_pkg::*;
#(
  parameter int W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:W-1]              data,
  output logic                      f,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [0:W-1]              sweep_data,
  output logic [tbl_depth(W)-1:0]   truth_tbl,
  output logic [W:0]                ones
);

  localparam int D = tbl_depth(W);

  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("parity_nor_sweep: W out of range 2..8");
  end

  state_t     state;
  state_t     state_d;
  logic [W:0] cnt;
  logic       last;
  logic       live_y;
  logic       sweep_y;

  parity_nor_eval #(.W(W)) u_live (
    .x (data),
    .y (live_y)
  );

  parity_nor_eval #(.W(W)) u_sweep (
    .x (cnt[W-1:0]),
    .y (sweep_y)
  );

  // Full-width compare keeps the guard bit of cnt meaningful.
  assign last       = (cnt == (W+1)'(D - 1));
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign sweep_data = busy ? cnt[W-1:0] : '0;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      truth_tbl <= '0;
      ones      <= '0;
      f         <= 1'b0;
    end else begin
      state <= state_d;
      f     <= live_y;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            truth_tbl <= '0;
            ones      <= '0;
          end
        end
        RUN: begin
          truth_tbl[cnt[W-1:0]] <= sweep_y;
          ones <= ones + (W+1)'(sweep_y);
          cnt  <= cnt + (W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
